// File: rtl/flash_play_pkg.sv
// Shared constants, state encoding and sample-half helper for the flash audio player.
package flash_play_pkg;

   localparam int          ADDR_W_DEF    = 23;
   localparam logic [22:0] LAST_ADDR_DEF = 23'h7FFFF;
   localparam int          SAMPLE_W_DEF  = 16;

   typedef logic [1:0] state_t;

   localparam state_t ST_IDLE    = 2'd0;
   localparam state_t ST_REQ     = 2'd1;
   localparam state_t ST_WAIT_DV = 2'd2;
   localparam state_t ST_DONE    = 2'd3;

   function automatic logic [SAMPLE_W_DEF-1:0] half_sel(
      input logic [2*SAMPLE_W_DEF-1:0] word,
      input logic                      upper
   );
      return upper ? word[2*SAMPLE_W_DEF-1:SAMPLE_W_DEF] : word[SAMPLE_W_DEF-1:0];
   endfunction

endpackage

// File: rtl/flash_play_ctrl_addr_step.sv
// Up/down flash word-address register with restart load and clip-boundary flag.
// LOOP_EN: stepping past a boundary wraps; otherwise the address holds at the boundary.
module flash_addr_step
   import flash_play_pkg::*;
#(
   parameter int                ADDR_W    = ADDR_W_DEF,
   parameter logic [ADDR_W-1:0] LAST_ADDR = LAST_ADDR_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              load_i,
   input  logic              back_i,
   input  logic              step_i,
   output logic [ADDR_W-1:0] addr_o,
   output logic              at_bound_o
);

   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [ADDR_W-1:0] start_addr;

   assign start_addr = back_i ? LAST_ADDR : '0;
   assign at_bound_o = back_i ? (addr_q == '0) : (addr_q == LAST_ADDR);
   assign addr_o     = addr_q;

   always_comb begin
      addr_d = addr_q;
      if (load_i)
         addr_d = start_addr;
      else if (step_i && !at_bound_o)
         addr_d = back_i ? (addr_q - ADDR_W'(1)) : (addr_q + ADDR_W'(1));
`ifdef LOOP_EN
      else if (step_i)
         addr_d = start_addr;
`endif
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) addr_q <= '0;
      else        addr_q <= addr_d;
   end

endmodule

// File: rtl/flash_play_ctrl.sv
// Flash audio playback sequencer: fetches 32-bit words over Avalon-MM and emits two samples per word.
// LOOP_EN: wrap at clip ends instead of stopping in DONE.
//
// state   | meaning
// IDLE    | waiting for sample_tick; may serve the buffered half
// REQ     | flash_read asserted until waitrequest drops
// WAIT_DV | waiting for readdatavalid
// DONE    | clip end reached; only restart exits
module flash_play_ctrl
   import flash_play_pkg::*;
#(
   parameter int                ADDR_W    = ADDR_W_DEF,
   parameter logic [ADDR_W-1:0] LAST_ADDR = LAST_ADDR_DEF,
   parameter int                SAMPLE_W  = SAMPLE_W_DEF
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                sample_tick,
   input  logic                play,
   input  logic                dir_back,
   input  logic                restart,
   output logic                flash_read,
   output logic [ADDR_W-1:0]   flash_addr,
   input  logic                flash_waitrequest,
   input  logic [31:0]         flash_readdata,
   input  logic                flash_readdatavalid,
   output logic [SAMPLE_W-1:0] sample_out,
   output logic                sample_valid,
   output logic                busy,
   output logic                done
);

   state_t              state_q, state_d;
   logic [SAMPLE_W-1:0] buf_q, buf_d;
   logic                buf_full_q, buf_full_d;
   logic [SAMPLE_W-1:0] sample_q, sample_d;
   logic                valid_q, valid_d;
   logic                done_q, done_d;
   logic                rst_pend_q, rst_pend_d;
   logic                load, step, at_bound;

   flash_addr_step #(
      .ADDR_W    (ADDR_W),
      .LAST_ADDR (LAST_ADDR)
   ) u_addr (
      .clk        (clk),
      .reset      (reset),
      .load_i     (load),
      .back_i     (dir_back),
      .step_i     (step),
      .addr_o     (flash_addr),
      .at_bound_o (at_bound)
   );

   always_comb begin
      state_d    = state_q;
      buf_d      = buf_q;
      buf_full_d = buf_full_q;
      sample_d   = sample_q;
      valid_d    = 1'b0;
      done_d     = done_q;
      rst_pend_d = rst_pend_q;
      load       = 1'b0;
      step       = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (restart) begin
               load       = 1'b1;
               buf_full_d = 1'b0;
               done_d     = 1'b0;
            end else if (sample_tick && play) begin
               if (!buf_full_q) begin
                  state_d = ST_REQ;
               end else begin
                  sample_d   = buf_q;
                  valid_d    = 1'b1;
                  buf_full_d = 1'b0;
`ifdef LOOP_EN
                  step = 1'b1;
`else
                  if (at_bound) begin
                     state_d = ST_DONE;
                     done_d  = 1'b1;
                  end else begin
                     step = 1'b1;
                  end
`endif
               end
            end
         end
         ST_REQ: begin
            if (restart) rst_pend_d = 1'b1;
            if (!flash_waitrequest) state_d = ST_WAIT_DV;
         end
         ST_WAIT_DV: begin
            if (restart) rst_pend_d = 1'b1;
            if (flash_readdatavalid) begin
               state_d = ST_IDLE;
               // A restart seen during the read discards the returning word.
               if (rst_pend_q || restart) begin
                  rst_pend_d = 1'b0;
                  load       = 1'b1;
                  buf_full_d = 1'b0;
                  done_d     = 1'b0;
               end else begin
                  sample_d   = half_sel(flash_readdata, dir_back);
                  buf_d      = half_sel(flash_readdata, !dir_back);
                  buf_full_d = 1'b1;
                  valid_d    = 1'b1;
               end
            end
         end
         default: begin
            if (restart) begin
               state_d    = ST_IDLE;
               load       = 1'b1;
               buf_full_d = 1'b0;
               done_d     = 1'b0;
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= ST_IDLE;
         buf_q      <= '0;
         buf_full_q <= 1'b0;
         sample_q   <= '0;
         valid_q    <= 1'b0;
         done_q     <= 1'b0;
         rst_pend_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         buf_q      <= buf_d;
         buf_full_q <= buf_full_d;
         sample_q   <= sample_d;
         valid_q    <= valid_d;
         done_q     <= done_d;
         rst_pend_q <= rst_pend_d;
      end
   end

   assign flash_read   = (state_q == ST_REQ);
   assign busy         = (state_q == ST_REQ) || (state_q == ST_WAIT_DV);
   assign sample_out   = sample_q;
   assign sample_valid = valid_q;
   assign done         = done_q;

endmodule

// File: tb/tb_flash_play_ctrl.sv
// Directed self-checking bench for flash_play_ctrl (expectations follow LOOP_EN when defined).
module tb_flash_play_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        sample_tick, play, dir_back, restart;
   logic        flash_read;
   logic [22:0] flash_addr;
   logic        flash_waitrequest;
   logic [31:0] flash_readdata;
   logic        flash_readdatavalid;
   logic [15:0] sample_out;
   logic        sample_valid, busy, done;

   int checks = 0;
   int errors = 0;
   int sv_count = 0;
   int sv_base;

   always #5 clk = ~clk;

   always @(posedge clk) if (sample_valid === 1'b1) sv_count++;

   flash_play_ctrl dut (
      .clk                 (clk),
      .reset               (reset),
      .sample_tick         (sample_tick),
      .play                (play),
      .dir_back            (dir_back),
      .restart             (restart),
      .flash_read          (flash_read),
      .flash_addr          (flash_addr),
      .flash_waitrequest   (flash_waitrequest),
      .flash_readdata      (flash_readdata),
      .flash_readdatavalid (flash_readdatavalid),
      .sample_out          (sample_out),
      .sample_valid        (sample_valid),
      .busy                (busy),
      .done                (done)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic pulse_tick();
      sample_tick = 1'b1;
      @(negedge clk);
      sample_tick = 1'b0;
   endtask

   task automatic pulse_restart();
      restart = 1'b1;
      @(negedge clk);
      restart = 1'b0;
   endtask

   task automatic fetch(input string tag, input logic [31:0] word,
                        input logic [22:0] exp_addr, input logic [15:0] exp_s);
      pulse_tick();
      check({tag, "_read"}, flash_read, 1'b1);
      check({tag, "_addr"}, flash_addr, exp_addr);
      @(negedge clk);
      check({tag, "_busy"}, busy, 1'b1);
      check({tag, "_read_off"}, flash_read, 1'b0);
      flash_readdatavalid = 1'b1;
      flash_readdata      = word;
      @(negedge clk);
      flash_readdatavalid = 1'b0;
      check({tag, "_valid"}, sample_valid, 1'b1);
      check({tag, "_sample"}, sample_out, exp_s);
   endtask

   task automatic second_half(input string tag, input logic [15:0] exp_s);
      pulse_tick();
      check({tag, "_valid"}, sample_valid, 1'b1);
      check({tag, "_sample"}, sample_out, exp_s);
      check({tag, "_noread"}, flash_read, 1'b0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b0; sample_tick = 1'b0; play = 1'b0; dir_back = 1'b0; restart = 1'b0;
      flash_waitrequest = 1'b0; flash_readdata = '0; flash_readdatavalid = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_read", flash_read, 1'b0);
      check("rst_addr", flash_addr, 23'h0);
      check("rst_valid", sample_valid, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_sample", sample_out, 16'h0);
      reset = 1'b1;
      @(negedge clk);

      // forward play: fetch then buffered half
      play = 1'b1;
      fetch("t1_w0", 32'hBBBB_AAAA, 23'h0, 16'hAAAA);
      second_half("t1_h1", 16'hBBBB);
      check("t1_addr_step", flash_addr, 23'h1);
      @(negedge clk);
      check("t1_valid_pulse", sample_valid, 1'b0);

      // pause ignores ticks
      play = 1'b0;
      pulse_tick();
      check("pause_valid", sample_valid, 1'b0);
      check("pause_read", flash_read, 1'b0);
      check("pause_busy", busy, 1'b0);
      play = 1'b1;

      // stall of 5 cycles with a dropped tick
      flash_waitrequest = 1'b1;
      pulse_tick();
      sv_base = sv_count;
      check("t3_read0", flash_read, 1'b1);
      check("t3_addr0", flash_addr, 23'h1);
      for (int i = 0; i < 4; i++) begin
         sample_tick = (i == 1);
         @(negedge clk);
         check("t3_read_stall", flash_read, 1'b1);
         check("t3_addr_stall", flash_addr, 23'h1);
      end
      sample_tick = 1'b0;
      flash_waitrequest = 1'b0;
      @(negedge clk);
      check("t3_wait_dv", busy, 1'b1);
      check("t3_read_off", flash_read, 1'b0);
      flash_readdatavalid = 1'b1;
      flash_readdata      = 32'h4444_3333;
      @(negedge clk);
      flash_readdatavalid = 1'b0;
      check("t3_valid", sample_valid, 1'b1);
      check("t3_sample", sample_out, 16'h3333);
      @(negedge clk);
      check("t3_one_valid", sv_count - sv_base, 1);
      second_half("t3_h1", 16'h4444);
      check("t3_addr_step", flash_addr, 23'h2);

      // backward after restart
      dir_back = 1'b1;
      pulse_restart();
      check("t2_restart_addr", flash_addr, 23'h7FFFF);
      check("t2_restart_valid", sample_valid, 1'b0);
      fetch("t2_w", 32'h2222_1111, 23'h7FFFF, 16'h2222);
      second_half("t2_h1", 16'h1111);
      check("t2_addr_step", flash_addr, 23'h7FFFE);

      // restart while waiting for data
      dir_back = 1'b0;
      pulse_tick();
      check("t5_read", flash_read, 1'b1);
      check("t5_addr", flash_addr, 23'h7FFFE);
      @(negedge clk);
      restart = 1'b1;
      @(negedge clk);
      restart = 1'b0;
      flash_readdatavalid = 1'b1;
      flash_readdata      = 32'hDEAD_BEEF;
      sv_base = sv_count;
      @(negedge clk);
      flash_readdatavalid = 1'b0;
      check("t5_discard_valid", sample_valid, 1'b0);
      check("t5_busy", busy, 1'b0);
      check("t5_addr_restart", flash_addr, 23'h0);
      @(negedge clk);
      check("t5_no_pulse", sv_count - sv_base, 0);
      fetch("t5_w0", 32'h6666_5555, 23'h0, 16'h5555);

      // clip end going forward
      dir_back = 1'b1;
      pulse_restart();
      check("t4_addr_last", flash_addr, 23'h7FFFF);
      dir_back = 1'b0;
      fetch("t4_w", 32'h8888_7777, 23'h7FFFF, 16'h7777);
      second_half("t4_h1", 16'h8888);
`ifdef LOOP_EN
      check("t4_wrap_addr", flash_addr, 23'h0);
      check("t4_wrap_done", done, 1'b0);
`else
      check("t4_done", done, 1'b1);
      check("t4_hold_addr", flash_addr, 23'h7FFFF);
      pulse_tick();
      check("t4_done_noread", flash_read, 1'b0);
      check("t4_done_novalid", sample_valid, 1'b0);
      check("t4_done_busy", busy, 1'b0);
`endif
      pulse_restart();
      check("t4_restart_done", done, 1'b0);
      check("t4_restart_addr", flash_addr, 23'h0);

      // asynchronous reset during a request
      fetch("t6_w0", 32'h1234_5678, 23'h0, 16'h5678);
      second_half("t6_h1", 16'h1234);
      pulse_tick();
      check("t6_req_read", flash_read, 1'b1);
      check("t6_req_addr", flash_addr, 23'h1);
      #2 reset = 1'b0;
      #1;
      check("t6_async_read", flash_read, 1'b0);
      check("t6_async_busy", busy, 1'b0);
      check("t6_async_addr", flash_addr, 23'h0);
      check("t6_async_sample", sample_out, 16'h0);
      check("t6_async_done", done, 1'b0);
      @(negedge clk);
      reset = 1'b1;
      flash_readdatavalid = 1'b1;
      flash_readdata      = 32'hFFFF_FFFF;
      @(negedge clk);
      flash_readdatavalid = 1'b0;
      check("t6_late_dv_valid", sample_valid, 1'b0);
      check("t6_late_dv_sample", sample_out, 16'h0);
      pulse_tick();
      check("t6_first_read", flash_read, 1'b1);
      check("t6_first_addr", flash_addr, 23'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
